// File: rtl/shit_drop_scheduler_if.sv
// Spawn handshake, hit inputs and per-slot draw outputs of the dropping scheduler.
// Latency: none, this is wiring only.
// Backpressure: none; spawn_ack/spawn_drop report acceptance one cycle after spawn_req.
interface shit_drop_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                         spawn_req;
  logic signed [10:0]           spawn_x;
  logic signed [10:0]           spawn_y;
  logic [NUM_SLOTS-1:0]         hit;
  logic                         spawn_ack;
  logic                         spawn_drop;
  logic [NUM_SLOTS-1:0][10:0]   topLeftX;
  logic [NUM_SLOTS-1:0][10:0]   topLeftY;
  logic [NUM_SLOTS-1:0]         isActive;
  logic [NUM_SLOTS-1:0]         splash;
  logic [3:0]                   active_count;

  // game logic / bird control side
  modport master (
    output spawn_req, spawn_x, spawn_y, hit,
    input  spawn_ack, spawn_drop, topLeftX, topLeftY, isActive, splash, active_count
  );

  // scheduler side
  modport slave (
    input  spawn_req, spawn_x, spawn_y, hit,
    output spawn_ack, spawn_drop, topLeftX, topLeftY, isActive, splash, active_count
  );
endinterface

// File: rtl/shit_drop_scheduler.sv
// Frame-rate spawn/fall/splash/free sequencer for up to NUM_SLOTS droppings; lowest free slot wins a spawn.
// Latency: spawn_req -> isActive/spawn_ack 1 cycle; startOfFrame -> topLeftY 1 cycle; active_count lags state by 1.
// Backpressure: none; a spawn with no IDLE slot is discarded and flagged on spawn_drop. Optional SHIT_GRAVITY_EN: accelerating fall.
module shit_drop_scheduler #(
  parameter int NUM_SLOTS     = 4,
  parameter int FALL_SPEED    = 2,
  parameter int MAX_SPEED     = 8,
  parameter int FLOOR_Y       = 464,
  parameter int SPLASH_FRAMES = 8
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  shit_drop_scheduler_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FALL   = 2'd1;
  localparam logic [1:0] ST_SPLASH = 2'd2;

  // velocity width covers whichever of the two speed settings is in use
  localparam int                VEL_W       = $clog2(MAX_SPEED + FALL_SPEED + 1);
  localparam logic [7:0]        SPLASH_LAST = 8'(SPLASH_FRAMES - 1);
  localparam logic signed [11:0] FLOOR_Y12  = 12'(FLOOR_Y);
  localparam logic [10:0]       FLOOR_Y11   = 11'(FLOOR_Y);

  logic [1:0]                 state      [NUM_SLOTS];
  logic [7:0]                 splash_cnt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0][10:0] pos_x;
  logic [NUM_SLOTS-1:0][10:0] pos_y;
  logic                       ack_q;
  logic                       drop_q;
  logic [3:0]                 count_q;

  logic [NUM_SLOTS-1:0]       idle_vec;
  logic [NUM_SLOTS-1:0]       active_vec;
  logic [NUM_SLOTS-1:0]       splash_vec;
  logic [NUM_SLOTS-1:0]       grant;
  logic [3:0]                 active_sum;
  logic [VEL_W-1:0]           step       [NUM_SLOTS];
  logic signed [11:0]         y_next     [NUM_SLOTS];

`ifdef SHIT_GRAVITY_EN
  localparam logic [VEL_W-1:0] MAX_V = VEL_W'(MAX_SPEED);
  logic [VEL_W-1:0] vel [NUM_SLOTS];

  // each slot falls by its own current velocity
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) step[i] = vel[i];
  end

  // velocity starts at 1, grows by 1 per frame that moved the slot, saturates at MAX_SPEED
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SLOTS; i++) vel[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (state[i] == ST_IDLE && bus.spawn_req && grant[i]) begin
          vel[i] <= VEL_W'(1);
        end else if (state[i] == ST_FALL && !bus.hit[i] && startOfFrame &&
                     y_next[i] < FLOOR_Y12 && vel[i] < MAX_V) begin
          vel[i] <= vel[i] + 1'b1;
        end
      end
    end
  end
`else
  localparam logic [VEL_W-1:0] FALL_V = VEL_W'(FALL_SPEED);

  // constant fall speed, no per-slot velocity storage
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) step[i] = FALL_V;
  end
`endif

  // candidate Y one frame on, at 12 bits so a fall near +1023 cannot wrap past the floor test
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      y_next[i] = $signed({pos_y[i][10], pos_y[i]}) + $signed(12'(step[i]));
    end
  end

  // state decode and live active-slot population count
  always_comb begin
    idle_vec   = '0;
    active_vec = '0;
    splash_vec = '0;
    active_sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idle_vec[i]   = (state[i] == ST_IDLE);
      active_vec[i] = (state[i] != ST_IDLE);
      splash_vec[i] = (state[i] == ST_SPLASH);
      active_sum    = active_sum + 4'(active_vec[i]);
    end
  end

  // one-hot grant of the lowest-index IDLE slot (descending loop leaves the lowest one)
  always_comb begin
    grant = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (idle_vec[i]) grant = NUM_SLOTS'(1) << i;
    end
  end

  // per-slot life cycle, position registers and spawn/count status
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state[i]      <= ST_IDLE;
        splash_cnt[i] <= '0;
        pos_x[i]      <= '0;
        pos_y[i]      <= '0;
      end
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (bus.spawn_req && grant[i]) begin
              state[i] <= ST_FALL;
              pos_x[i] <= bus.spawn_x;
              pos_y[i] <= bus.spawn_y;
            end
          end
          ST_FALL: begin
            // a hit freezes the dropping where it is, even on a landing frame
            if (bus.hit[i]) begin
              state[i]      <= ST_SPLASH;
              splash_cnt[i] <= '0;
            end else if (startOfFrame) begin
              if (y_next[i] >= FLOOR_Y12) begin
                pos_y[i]      <= FLOOR_Y11;
                state[i]      <= ST_SPLASH;
                splash_cnt[i] <= '0;
              end else begin
                pos_y[i] <= y_next[i][10:0];
              end
            end
          end
          ST_SPLASH: begin
            if (startOfFrame) begin
              if (splash_cnt[i] == SPLASH_LAST) begin
                state[i]      <= ST_IDLE;
                splash_cnt[i] <= '0;
              end else begin
                splash_cnt[i] <= splash_cnt[i] + 8'd1;
              end
            end
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
      ack_q   <= bus.spawn_req && (|idle_vec);
      drop_q  <= bus.spawn_req && !(|idle_vec);
      count_q <= active_sum;
    end
  end

  assign bus.topLeftX     = pos_x;
  assign bus.topLeftY     = pos_y;
  assign bus.isActive     = active_vec;
  assign bus.splash       = splash_vec;
  assign bus.spawn_ack    = ack_q;
  assign bus.spawn_drop   = drop_q;
  assign bus.active_count = count_q;

endmodule

// File: tb/tb_shit_drop_scheduler.sv
// Bench for shit_drop_scheduler: vector table, corner-case sequences, then random traffic against a frame-level model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; every wait is a fixed cycle count.
module tb_shit_drop_scheduler;
  localparam int NS            = 4;
  localparam int FALL_SPEED    = 2;
  localparam int MAX_SPEED     = 8;
  localparam int FLOOR_Y       = 464;
  localparam int SPLASH_FRAMES = 8;
`ifdef SHIT_GRAVITY_EN
  localparam int V0 = 1;
`else
  localparam int V0 = FALL_SPEED;
`endif

  logic clk          = 1'b0;
  logic resetN       = 1'b0;
  logic startOfFrame = 1'b0;

  shit_drop_scheduler_if #(.NUM_SLOTS(NS)) bus();

  shit_drop_scheduler #(
    .NUM_SLOTS(NS), .FALL_SPEED(FALL_SPEED), .MAX_SPEED(MAX_SPEED),
    .FLOOR_Y(FLOOR_Y), .SPLASH_FRAMES(SPLASH_FRAMES)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit req, input int x, input int y, input bit sof, input logic [NS-1:0] h);
    bus.spawn_req = req;
    bus.spawn_x   = 11'(x);
    bus.spawn_y   = 11'(y);
    startOfFrame  = sof;
    bus.hit       = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // apply one cycle of inputs, return to quiet inputs after the edge
  task automatic cycle(input bit req, input int x, input int y, input bit sof, input logic [NS-1:0] h);
    drive(req, x, y, sof, h);
    tick();
    drive(0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, '0);
    resetN = 1'b0;
    repeat (2) tick();
    resetN = 1'b1;
  endtask

  // ---------------- frame-level reference model (0=idle, 1=falling, 2=splashing)
  int m_st [NS];
  int m_x  [NS];
  int m_y  [NS];
  int m_v  [NS];
  int m_c  [NS];
  int m_ack, m_drop, m_cnt;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_v[i] = 0; m_c[i] = 0;
    end
    m_ack = 0; m_drop = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit req, input int x, input int y, input bit sof, input logic [NS-1:0] h);
    int g;
    int act;
    g = -1;
    act = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_st[i] != 0) act++;
      else if (g < 0) g = i;
    end
    m_cnt  = act;
    m_ack  = (req && g >= 0) ? 1 : 0;
    m_drop = (req && g < 0) ? 1 : 0;
    for (int i = 0; i < NS; i++) begin
      if (m_st[i] == 0) begin
        if (req && g == i) begin
          m_st[i] = 1; m_x[i] = x; m_y[i] = y; m_v[i] = V0;
        end
      end else if (m_st[i] == 1) begin
        if (h[i]) begin
          m_st[i] = 2; m_c[i] = 0;
        end else if (sof) begin
          if (m_y[i] + m_v[i] >= FLOOR_Y) begin
            m_y[i] = FLOOR_Y; m_st[i] = 2; m_c[i] = 0;
          end else begin
            m_y[i] = m_y[i] + m_v[i];
`ifdef SHIT_GRAVITY_EN
            if (m_v[i] < MAX_SPEED) m_v[i]++;
`endif
          end
        end
      end else if (sof) begin
        if (m_c[i] == SPLASH_FRAMES - 1) begin
          m_st[i] = 0; m_c[i] = 0;
        end else begin
          m_c[i]++;
        end
      end
    end
  endtask

  // ---------------- directed vector table
  typedef struct {
    bit          req;
    int          x;
    int          y;
    bit          sof;
    logic [3:0]  hit;
    bit          e_ack;
    bit          e_drop;
    logic [3:0]  e_act;
    logic [3:0]  e_spl;
    int          e_cnt;
    int          e_y0;
    int          e_y1;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [NS-1:0] e_act;
    logic [NS-1:0] e_spl;
    int            gy [4];

    tbl[0]  = '{1, 100, 50,  0, 4'b0000, 1, 0, 4'b0001, 4'b0000, 0, 50, 0};
    tbl[1]  = '{0, 0,   0,   1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 1, 52, 0};
    tbl[2]  = '{0, 0,   0,   0, 4'b0000, 0, 0, 4'b0001, 4'b0000, 1, 52, 0};
    tbl[3]  = '{0, 0,   0,   1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 1, 54, 0};
    tbl[4]  = '{0, 0,   0,   1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 1, 56, 0};
    tbl[5]  = '{1, 10,  200, 0, 4'b0000, 1, 0, 4'b0011, 4'b0000, 1, 56, 200};
    tbl[6]  = '{0, 0,   0,   0, 4'b0000, 0, 0, 4'b0011, 4'b0000, 2, 56, 200};
    tbl[7]  = '{1, 20,  300, 0, 4'b0000, 1, 0, 4'b0111, 4'b0000, 2, 56, 200};
    tbl[8]  = '{0, 0,   0,   0, 4'b0000, 0, 0, 4'b0111, 4'b0000, 3, 56, 200};
    tbl[9]  = '{1, 30,  300, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 3, 56, 200};
    tbl[10] = '{0, 0,   0,   0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 4, 56, 200};
    tbl[11] = '{1, 40,  300, 0, 4'b0000, 0, 1, 4'b1111, 4'b0000, 4, 56, 200};
    tbl[12] = '{0, 0,   0,   0, 4'b0010, 0, 0, 4'b1111, 4'b0010, 4, 56, 200};
    tbl[13] = '{0, 0,   0,   1, 4'b0000, 0, 0, 4'b1111, 4'b0010, 4, 58, 200};
    tbl[14] = '{0, 0,   0,   1, 4'b0010, 0, 0, 4'b1111, 4'b0010, 4, 60, 200};

    // reset state, sampled while reset is held
    drive(0, 0, 0, 0, '0);
    #12;
    check("rst_act",  bus.isActive, 0);
    check("rst_spl",  bus.splash, 0);
    check("rst_x",    bus.topLeftX, 0);
    check("rst_y",    bus.topLeftY, 0);
    check("rst_ack",  bus.spawn_ack, 0);
    check("rst_drop", bus.spawn_drop, 0);
    check("rst_cnt",  bus.active_count, 0);
    do_reset();

    for (int r = 0; r < 15; r++) begin
      cycle(tbl[r].req, tbl[r].x, tbl[r].y, tbl[r].sof, tbl[r].hit);
      check($sformatf("t%0d_ack", r),  bus.spawn_ack,    tbl[r].e_ack);
      check($sformatf("t%0d_drop", r), bus.spawn_drop,   tbl[r].e_drop);
      check($sformatf("t%0d_act", r),  bus.isActive,     tbl[r].e_act);
      check($sformatf("t%0d_spl", r),  bus.splash,       tbl[r].e_spl);
      check($sformatf("t%0d_cnt", r),  bus.active_count, tbl[r].e_cnt);
      check($sformatf("t%0d_y1", r),   $signed(bus.topLeftY[1]), tbl[r].e_y1);
`ifndef SHIT_GRAVITY_EN
      check($sformatf("t%0d_y0", r),   $signed(bus.topLeftY[0]), tbl[r].e_y0);
`endif
    end
    check("t_x0", $signed(bus.topLeftX[0]), 100);

    // landing, full splash period, and a spawn on the cycle slot 0 frees
    do_reset();
    cycle(1, 5, FLOOR_Y - 1, 0, '0);
    check("land_ack", bus.spawn_ack, 1);
    cycle(0, 0, 0, 1, '0);
    check("land_y", $signed(bus.topLeftY[0]), FLOOR_Y);
    check("land_spl", bus.splash[0], 1);
    repeat (SPLASH_FRAMES - 1) cycle(0, 0, 0, 1, '0);
    check("spl_hold", bus.isActive[0], 1);
    cycle(1, 7, 100, 1, '0);
    check("free_act", bus.isActive, 4'b0010);
    check("free_spl", bus.splash, 0);
    check("free_ack", bus.spawn_ack, 1);
    cycle(0, 0, 0, 0, '0);
    check("free_cnt", bus.active_count, 1);

    // spawn coinciding with a frame, then hit coinciding with a landing
    do_reset();
    cycle(1, 3, 10, 1, '0);
    check("sof_y_load", $signed(bus.topLeftY[0]), 10);
    cycle(0, 0, 0, 1, '0);
    check("sof_y_next", $signed(bus.topLeftY[0]), 10 + V0);
    cycle(1, 9, FLOOR_Y - 1, 0, '0);
    check("hf_ack", bus.spawn_ack, 1);
    cycle(0, 0, 0, 1, 4'b0010);
    check("hf_spl", bus.splash[1], 1);
    check("hf_y", $signed(bus.topLeftY[1]), FLOOR_Y - 1);

    // asynchronous reset with three slots busy
    cycle(1, 11, 40, 0, '0);
    cycle(0, 0, 0, 0, '0);
    check("ar_cnt_pre", bus.active_count, 3);
    @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    check("ar_act", bus.isActive, 0);
    check("ar_x",   bus.topLeftX, 0);
    check("ar_y",   bus.topLeftY, 0);
    check("ar_cnt", bus.active_count, 0);
    #2;
    resetN = 1'b1;
    tick();

`ifdef SHIT_GRAVITY_EN
    gy = '{1, 3, 6, 10};
    do_reset();
    cycle(1, 0, 0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 1, '0);
      check($sformatf("grav_y%0d", k), $signed(bus.topLeftY[0]), gy[k]);
    end
`else
    gy = '{0, 0, 0, 0};
`endif

    // random traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      bit            req;
      bit            sof;
      int            x;
      int            y;
      logic [NS-1:0] h;
      req = ($urandom % 4) == 0;
      sof = ($urandom % 3) == 0;
      x   = int'($urandom_range(0, 639));
      y   = int'($urandom_range(0, 490)) - 20;
      h   = (($urandom % 12) == 0) ? NS'($urandom) : '0;
      drive(req, x, y, sof, h);
      model_step(req, x, y, sof, h);
      tick();
      e_act = '0;
      e_spl = '0;
      for (int i = 0; i < NS; i++) begin
        e_act[i] = (m_st[i] != 0);
        e_spl[i] = (m_st[i] == 2);
      end
      check("r_ack",  bus.spawn_ack,    m_ack);
      check("r_drop", bus.spawn_drop,   m_drop);
      check("r_act",  bus.isActive,     e_act);
      check("r_spl",  bus.splash,       e_spl);
      check("r_cnt",  bus.active_count, m_cnt);
      for (int i = 0; i < NS; i++) begin
        check($sformatf("r_x%0d", i), $signed(bus.topLeftX[i]), m_x[i]);
        check($sformatf("r_y%0d", i), $signed(bus.topLeftY[i]), m_y[i]);
      end
    end
    drive(0, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
